// File: rtl/pipe_regr_pkg.sv
// rtl/pipe_regr_pkg.sv - shared constants and helpers for the elastic pipeline register
package pipe_regr_pkg;

  localparam int COLLAPSE_ON  = 1;
  localparam int COLLAPSE_OFF = 0;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int clog2p1(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_regr_stage.sv
// rtl/pipe_regr_stage.sv - one pipeline slot: N-bit data register plus its valid bit
// A load with dv=0 empties the slot but keeps the stale data, avoiding needless data toggles.
module pipe_regr_stage
  import pipe_regr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         dv,
  output logic [N-1:0] q,
  output logic         qv
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q  <= '0;
      qv <= 1'b0;
    end else if (load) begin
      qv <= dv;
      if (dv) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/pipe_regr.sv
// rtl/pipe_regr.sv - DEPTH-stage stallable, flushable elastic pipeline register
// Stage 0 takes the input, stage DEPTH-1 drives the output; COLLAPSE selects the advance policy.
module pipe_regr
  import pipe_regr_pkg::*;
#(
  parameter int N        = 8,
  parameter int DEPTH    = 3,
  parameter int COLLAPSE = COLLAPSE_ON
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        hold,
  input  logic                        in_valid,
  input  logic [N-1:0]                in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [N-1:0]                out_data,
  input  logic                        out_ready,
  output logic [clog2p1(DEPTH)-1:0]   count
);

  localparam int CW = clog2p1(DEPTH);

  logic [DEPTH-1:0]        v;
  logic [DEPTH-1:0]        load;
  logic [DEPTH-1:0][N-1:0] q;
  logic                    in_fire;
  logic                    out_fire;

  generate
    if (COLLAPSE == COLLAPSE_ON) begin : g_collapse
      logic [DEPTH-1:0] adv;

      // A slot can accept when it is empty or its occupant moves on this cycle.
      always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = ~v[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
          adv[i] = ~v[i] | adv[i+1];
        end
      end

      assign load     = adv & {DEPTH{~hold}};
      assign in_ready = adv[0] & ~hold & ~clear & ~rst;
    end else begin : g_lockstep
      logic step;

      assign step     = (~v[DEPTH-1] | out_ready) & ~hold & ~clear;
      assign load     = {DEPTH{step}};
      assign in_ready = step & ~rst;
    end
  endgenerate

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [N-1:0] d;
    logic         dv;

    if (i == 0) begin : g_head
      assign d  = in_data;
      assign dv = in_valid;
    end else begin : g_body
      assign d  = q[i-1];
      assign dv = v[i-1];
    end

    pipe_regr_stage #(
      .N (N)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .load  (load[i]),
      .d     (d),
      .dv    (dv),
      .q     (q[i]),
      .qv    (v[i])
    );
  end

  assign out_valid = v[DEPTH-1] & ~hold & ~clear & ~rst;
  assign out_data  = q[DEPTH-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Both fire signals are already gated off by hold, so hold freezes the count for free.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else begin
      count <= count + CW'(in_fire) - CW'(out_fire);
    end
  end

endmodule

// File: tb/tb_pipe_regr.sv
// tb/tb_pipe_regr.sv - bench for pipe_regr in collapsing (index 1) and lockstep (index 0) modes
module tb_pipe_regr;
  import pipe_regr_pkg::*;

  localparam int N = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [1:0]          clr, hld, ivld, ordy;
  logic [1:0][N-1:0]   din;
  logic                c_ir, c_ov, l_ir, l_ov;
  logic [N-1:0]        c_od, l_od;
  logic [1:0]          c_cnt, l_cnt;

  int checks = 0;
  int failures = 0;

  pipe_regr #(.N(N), .DEPTH(D), .COLLAPSE(COLLAPSE_ON)) u_col (
    .clk(clk), .rst(rst), .clear(clr[1]), .hold(hld[1]),
    .in_valid(ivld[1]), .in_data(din[1]), .in_ready(c_ir),
    .out_valid(c_ov), .out_data(c_od), .out_ready(ordy[1]), .count(c_cnt)
  );

  pipe_regr #(.N(N), .DEPTH(D), .COLLAPSE(COLLAPSE_OFF)) u_lck (
    .clk(clk), .rst(rst), .clear(clr[0]), .hold(hld[0]),
    .in_valid(ivld[0]), .in_data(din[0]), .in_ready(l_ir),
    .out_valid(l_ov), .out_data(l_od), .out_ready(ordy[0]), .count(l_cnt)
  );

  typedef struct {
    int sel;
    bit rst, clr, hld, iv;
    logic [7:0] id;
    bit ord, ir, ov, chkd;
    logic [7:0] od;
    int cnt;
  } vec_t;

  function automatic vec_t mk(int sel, bit r, bit c, bit h, bit iv, logic [7:0] id, bit ord,
                              bit ir, bit ov, bit chkd, logic [7:0] od, int cnt);
    vec_t x;
    x.sel = sel; x.rst = r; x.clr = c; x.hld = h; x.iv = iv; x.id = id; x.ord = ord;
    x.ir = ir; x.ov = ov; x.chkd = chkd; x.od = od; x.cnt = cnt;
    return x;
  endfunction

  // Reference model: collapsing pipe as a list of items with positions, lockstep as a shift line.
  typedef struct { int pos; logic [7:0] d; } item_t;
  item_t      cq[$];
  bit         lv[D];
  logic [7:0] ld[D];
  int         npos[D];
  bit         e_ir[2], e_ov[2], ofire[2], ifire[2];
  logic [7:0] e_od[2];
  int         e_cnt[2];
  bit         step0;

  task automatic model_eval();
    bit g;
    int lim;
    int k0;
    int pc;
    g = !rst && !clr[1] && !hld[1];
    e_ov[1] = g && cq.size() > 0 && cq[0].pos == D - 1;
    e_od[1] = (cq.size() > 0) ? cq[0].d : 8'h00;
    ofire[1] = e_ov[1] && ordy[1];
    lim = D - 1;
    k0 = ofire[1] ? 1 : 0;
    for (int k = k0; k < cq.size(); k++) begin
      npos[k] = (cq[k].pos + 1 <= lim) ? cq[k].pos + 1 : cq[k].pos;
      lim = npos[k] - 1;
    end
    e_ir[1]  = g && lim >= 0;
    e_cnt[1] = cq.size();
    ifire[1] = e_ir[1] && ivld[1];

    step0 = (!lv[D-1] || ordy[0]) && !hld[0] && !clr[0];
    e_ov[0] = lv[D-1] && !hld[0] && !clr[0] && !rst;
    e_od[0] = ld[D-1];
    e_ir[0] = step0 && !rst;
    pc = 0;
    for (int i = 0; i < D; i++) pc += lv[i] ? 1 : 0;
    e_cnt[0] = pc;
    ofire[0] = e_ov[0] && ordy[0];
    ifire[0] = e_ir[0] && ivld[0];
  endtask

  task automatic model_update();
    item_t it;
    if (rst || clr[1]) begin
      cq.delete();
    end else if (!hld[1]) begin
      for (int k = (ofire[1] ? 1 : 0); k < cq.size(); k++) cq[k].pos = npos[k];
      if (ofire[1]) void'(cq.pop_front());
      if (ifire[1]) begin
        it.pos = 0;
        it.d = din[1];
        cq.push_back(it);
      end
    end
    if (rst || clr[0]) begin
      for (int i = 0; i < D; i++) begin lv[i] = 1'b0; ld[i] = 8'h00; end
    end else if (step0) begin
      for (int i = D - 1; i > 0; i--) begin
        lv[i] = lv[i-1];
        if (lv[i-1]) ld[i] = ld[i-1];
      end
      lv[0] = ivld[0];
      if (ivld[0]) ld[0] = din[0];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] g_ir(int m);  return m ? 32'(c_ir)  : 32'(l_ir);  endfunction
  function automatic logic [31:0] g_ov(int m);  return m ? 32'(c_ov)  : 32'(l_ov);  endfunction
  function automatic logic [31:0] g_od(int m);  return m ? 32'(c_od)  : 32'(l_od);  endfunction
  function automatic logic [31:0] g_cnt(int m); return m ? 32'(c_cnt) : 32'(l_cnt); endfunction

  task automatic run_cycle(input bit use_row, input vec_t r, input int idx);
    @(negedge clk);
    model_eval();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("model m%0d in_ready", m), g_ir(m), 32'(e_ir[m]));
      chk($sformatf("model m%0d out_valid", m), g_ov(m), 32'(e_ov[m]));
      chk($sformatf("model m%0d count", m), g_cnt(m), 32'(e_cnt[m]));
      if (e_ov[m]) chk($sformatf("model m%0d out_data", m), g_od(m), 32'(e_od[m]));
    end
    if (use_row) begin
      chk($sformatf("row%0d in_ready", idx), g_ir(r.sel), 32'(r.ir));
      chk($sformatf("row%0d out_valid", idx), g_ov(r.sel), 32'(r.ov));
      chk($sformatf("row%0d count", idx), g_cnt(r.sel), 32'(r.cnt));
      if (r.chkd) chk($sformatf("row%0d out_data", idx), g_od(r.sel), 32'(r.od));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  vec_t tbl[$];
  vec_t dummy;

  initial begin
    // Reset and idle
    tbl.push_back(mk(1, 1,0,0,1,8'hAA,1, 0,0,1,8'h00,0));
    tbl.push_back(mk(0, 1,0,0,1,8'hAA,1, 0,0,1,8'h00,0));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,0,0,8'h00,0));
    tbl.push_back(mk(0, 0,0,0,0,8'h00,1, 1,0,0,8'h00,0));
    // Latency, collapsing
    tbl.push_back(mk(1, 0,0,0,1,8'h11,1, 1,0,0,8'h00,0));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,0,0,8'h00,1));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,0,0,8'h00,1));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,1,1,8'h11,1));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,0,0,8'h00,0));
    // Back-pressure with bubble, collapsing
    tbl.push_back(mk(1, 0,0,0,1,8'h01,0, 1,0,0,8'h00,0));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,0, 1,0,0,8'h00,1));
    tbl.push_back(mk(1, 0,0,0,1,8'h02,0, 1,0,0,8'h00,1));
    tbl.push_back(mk(1, 0,0,0,1,8'h03,0, 1,1,1,8'h01,2));
    tbl.push_back(mk(1, 0,0,0,1,8'h04,0, 0,1,1,8'h01,3));
    tbl.push_back(mk(1, 0,0,0,1,8'h04,1, 1,1,1,8'h01,3));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,1,1,8'h02,3));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,1,1,8'h03,2));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,1,1,8'h04,1));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,0,0,8'h00,0));
    // Same stimulus, lockstep: bubble preserved
    tbl.push_back(mk(0, 0,0,0,1,8'h01,0, 1,0,0,8'h00,0));
    tbl.push_back(mk(0, 0,0,0,0,8'h00,0, 1,0,0,8'h00,1));
    tbl.push_back(mk(0, 0,0,0,1,8'h02,0, 1,0,0,8'h00,1));
    tbl.push_back(mk(0, 0,0,0,1,8'h03,0, 0,1,1,8'h01,2));
    tbl.push_back(mk(0, 0,0,0,1,8'h03,1, 1,1,1,8'h01,2));
    tbl.push_back(mk(0, 0,0,0,1,8'h04,1, 1,0,0,8'h00,2));
    tbl.push_back(mk(0, 0,0,0,0,8'h00,1, 1,1,1,8'h02,3));
    tbl.push_back(mk(0, 0,0,0,0,8'h00,1, 1,1,1,8'h03,2));
    tbl.push_back(mk(0, 0,0,0,0,8'h00,1, 1,1,1,8'h04,1));
    tbl.push_back(mk(0, 0,0,0,0,8'h00,1, 1,0,0,8'h00,0));
    // Hold with a full pipe, then clear and hold together
    tbl.push_back(mk(1, 0,0,0,1,8'h21,0, 1,0,0,8'h00,0));
    tbl.push_back(mk(1, 0,0,0,1,8'h22,0, 1,0,0,8'h00,1));
    tbl.push_back(mk(1, 0,0,0,1,8'h23,0, 1,0,0,8'h00,2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0,0,1,1,8'h24,1, 0,0,1,8'h21,3));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,1,1,8'h21,3));
    tbl.push_back(mk(1, 0,0,0,1,8'h25,0, 1,1,1,8'h22,2));
    tbl.push_back(mk(1, 0,1,1,1,8'h26,1, 0,0,0,8'h00,3));
    tbl.push_back(mk(1, 0,0,0,0,8'h00,1, 1,0,1,8'h00,0));

    for (int i = 0; i < D; i++) begin lv[i] = 1'b0; ld[i] = 8'h00; end
    dummy = mk(0, 0,0,0,0,8'h00,0, 0,0,0,8'h00,0);
    rst = 1'b1; clr = '0; hld = '0; ivld = '0; ordy = '1; din = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      for (int m = 0; m < 2; m++) begin
        if (m == tbl[i].sel) begin
          clr[m] = tbl[i].clr; hld[m] = tbl[i].hld; ivld[m] = tbl[i].iv;
          din[m] = tbl[i].id; ordy[m] = tbl[i].ord;
        end else begin
          clr[m] = 1'b0; hld[m] = 1'b0; ivld[m] = 1'b0; din[m] = 8'h00; ordy[m] = 1'b1;
        end
      end
      run_cycle(1'b1, tbl[i], i);
    end

    // Randomized traffic; upstream keeps an item steady until it is taken.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int m = 0; m < 2; m++) begin
        clr[m]  = ($urandom_range(0, 39) == 0);
        hld[m]  = ($urandom_range(0, 7) == 0);
        ordy[m] = ($urandom_range(0, 99) < (((cyc / 400) % 2) != 0 ? 25 : 80));
        if (!ivld[m] || ifire[m]) begin
          ivld[m] = ($urandom_range(0, 2) != 0);
          din[m]  = 8'($urandom);
        end
      end
      run_cycle(1'b0, dummy, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_regr.md
Name: pipe_regr

Overview:
- Parametrised elastic pipeline register: DEPTH stages of N-bit data, each stage with its own valid bit.
- Valid/ready handshake on both sides, a global hold (stall) and a synchronous clear (flush).
- Selectable bubble-collapsing or lockstep advance.
- Sits between datapath units wherever a multi-cycle, stallable, flushable delay line is needed; occupancy count exported for flow control.

Parameters:
- N, 8, data width in bits (>=1)
- DEPTH, 3, number of register stages (>=1)
- COLLAPSE, 1, 1 = bubble-collapsing (stages advance independently into empty slots); 0 = lockstep (all stages shift together)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush of all stages
- hold  in  1  global stall; freezes all state
- in_valid  in  1  upstream item present
- in_data  in  N  upstream data
- in_ready  out  1  pipe accepts in_data this cycle
- out_valid  out  1  item presented downstream
- out_data  out  N  downstream data (stage DEPTH-1)
- out_ready  in  1  downstream accepts
- count  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Stage 0 is the input side; stage DEPTH-1 drives out_data.
- Priority each cycle: rst > clear > hold > normal advance.
- rst or clear at edge: all valid bits 0, all data 0, count 0.
  - During a rst/clear cycle: in_ready=0 and out_valid=0 (combinational gate); no transfer occurs on either side.
- hold=1 (clear=0): no state changes; in_ready=0, out_valid=0; out_data keeps its value.
- Transfers:
  - out_fire = out_valid & out_ready.
  - in_fire = in_valid & in_ready.
  - out_valid = v[DEPTH-1] & ~hold & ~clear & ~rst.
- COLLAPSE=1:
  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - adv[i] = ~v[i] | adv[i+1].
  - Stage i loads from stage i-1 (stage 0 from input) when adv[i].
  - The loaded valid equals the source valid (in_valid for stage 0).
  - in_ready = adv[0] & ~hold & ~clear & ~rst; this is a combinational chain of depth DEPTH.
- COLLAPSE=0:
  - step = (~v[DEPTH-1] | out_ready) & ~hold & ~clear.
  - When step=1, all stages shift by one; stage 0 takes in_valid/in_data. Bubbles are preserved.
  - in_ready = step & ~rst.
- A stage loaded with valid 0 retains its old data; data is only guaranteed meaningful when valid.
- Latency, empty pipe, no stall: item accepted at edge t is at stage DEPTH-1 after edge t+DEPTH-1; out_valid=1 in the cycle following that edge (DEPTH cycles after in_fire).
- Throughput: one item per cycle when out_ready=1 and hold=0.
- Full pipe (all v=1) with out_ready=0: in_ready=0 in both modes.
- Full pipe with out_ready=1: in_ready=1; simultaneous in_fire and out_fire; count unchanged.
- Count:
  - count_next = count + in_fire - out_fire.
  - Registered, and equals popcount(v) at all times.
  - Never exceeds DEPTH; never underflows.
- in_valid while in_ready=0: item is not taken. Upstream must hold in_valid/in_data until in_fire; the block does not check this.
- Reset or clear mid-stream discards all in-flight items; there is no partial drain.

Decomposition:
- pipe_regr_pkg:
  - COLLAPSE_ON / COLLAPSE_OFF constants.
  - count width function clog2p1(depth).
- Sub-module pipe_regr_stage: one N-bit data register plus valid bit.
  - Inputs: load, clear, d, dv.
  - Sync active-high rst.
  - Instantiated DEPTH times via generate; adv/in_ready logic lives in the top.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with in_valid=1, in_data=8'hAA → out_valid=0, in_ready=0, count=0, out_data=8'h00; after release, in_ready=1.
- Latency (N=8, DEPTH=3, COLLAPSE=1): send 8'h11 at cycle 0, out_ready=1 → out_valid=1 with out_data=8'h11 at cycle 3; count 1 during cycles 1-3, 0 after the cycle-3 out_fire.
- Back-pressure/collapse:
  - Stimulus: out_ready=0; send 8'h01 at cycle 0, idle cycle 1, then 8'h02, 8'h03, 8'h04 at cycles 2-4.
  - Pipe fills to count=3: 8'h01 is presented at output; 8'h02 and 8'h03 fill stages 0-1 and the bubble is collapsed; in_ready=0 at cycle 4, so 8'h04 is held.
  - Raise out_ready → out_data 8'h01, 8'h02, 8'h03, 8'h04 on consecutive cycles.
- Lockstep (COLLAPSE=0): same stimulus → out_valid pattern 1,0,1,1,1 when drained, preserving the bubble; in_ready=0 whenever v[2]=1 and out_ready=0.
- Hold: pipe with 3 items, out_ready=1, hold=1 for 4 cycles → out_valid=0, in_ready=0, count=3 and out_data unchanged throughout; draining resumes the cycle after hold falls.
- Clear vs hold: full pipe with clear=1 and hold=1 in the same cycle → next cycle count=0, all valids 0, out_data=8'h00; the in_data offered during the clear cycle is not accepted.
